// File: rtl/snake_item_placer.sv
`default_nettype none
// ============================================================================
// Module  : snake_item_placer
// Purpose : LFSR-driven food placement, rejecting head and body collisions.
// Rev     : 1.0
// ============================================================================
module snake_item_placer #(
    parameter int          XSIZE    = 48,
    parameter int          YSIZE    = 64,
    parameter int          MAX_SIZE = 100,
    parameter int          MAX_TRY  = 16,
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int          ITEM_X0  = 12,
    parameter int          ITEM_Y0  = 32
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Req,
    input  logic [11:0] i_Size,
    input  logic [5:0]  i_Head_x,
    input  logic [5:0]  i_Head_y,
    output logic        o_Body_Rd,
    output logic [6:0]  o_Body_Addr,
    input  logic [5:0]  i_Body_x,
    input  logic [5:0]  i_Body_y,
    output logic [5:0]  o_Item_x,
    output logic [5:0]  o_Item_y,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Fail
);

    localparam int          TW     = $clog2(MAX_TRY + 1);
    localparam logic [5:0]  X_HI   = 6'(XSIZE - 2);
    localparam logic [5:0]  Y_HI   = 6'(YSIZE - 2);
    localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRY - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DRAW = 3'd1,
        SCAN = 3'd2,
        DONE = 3'd3,
        FAIL = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     lfsr_q;
    logic [6:0]      size_q, size_d;
    logic [5:0]      head_x_q, head_x_d, head_y_q, head_y_d;
    logic [5:0]      cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [5:0]      item_x_q, item_x_d, item_y_q, item_y_d;
    logic [6:0]      idx_q, idx_d;
    logic [6:0]      addr_q;
    logic [TW-1:0]   try_q, try_d;

    logic [5:0]      w_cand_x, w_cand_y;
    logic            w_in_range;
    logic [6:0]      w_size_clamp;
    logic            w_rd;
    logic            w_hit;

    assign w_cand_x     = lfsr_q[5:0];
    assign w_cand_y     = lfsr_q[13:8];
    assign w_in_range   = (w_cand_x >= 6'd1) && (w_cand_x <= X_HI) &&
                          (w_cand_y >= 6'd1) && (w_cand_y <= Y_HI);
    assign w_size_clamp = (i_Size > 12'(MAX_SIZE)) ? 7'(MAX_SIZE) : i_Size[6:0];

    // Reads issue while idx < size; the extra final cycle only compares.
    assign w_rd        = (state_q == SCAN) && (idx_q < size_q);
    assign o_Body_Rd   = w_rd;
    assign o_Body_Addr = w_rd ? idx_q : addr_q;
    assign o_Item_x    = item_x_q;
    assign o_Item_y    = item_y_q;
    assign o_Busy      = (state_q != IDLE);
    assign o_Done      = (state_q == DONE);
    assign o_Fail      = (state_q == FAIL);

    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        head_x_d = head_x_q;
        head_y_d = head_y_q;
        cand_x_d = cand_x_q;
        cand_y_d = cand_y_q;
        item_x_d = item_x_q;
        item_y_d = item_y_q;
        idx_d    = idx_q;
        try_d    = try_q;
        w_hit    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_Req) begin
                    size_d   = w_size_clamp;
                    head_x_d = i_Head_x;
                    head_y_d = i_Head_y;
                    try_d    = '0;
                    state_d  = DRAW;
                end
            end
            DRAW: begin
                if (w_in_range) begin
                    if ((w_cand_x == head_x_q) && (w_cand_y == head_y_q)) begin
                        w_hit = 1'b1;
                    end else begin
                        cand_x_d = w_cand_x;
                        cand_y_d = w_cand_y;
                        idx_d    = '0;
                        if (size_q == 7'd0) begin
                            item_x_d = w_cand_x;
                            item_y_d = w_cand_y;
                            state_d  = DONE;
                        end else begin
                            state_d  = SCAN;
                        end
                    end
                end
            end
            SCAN: begin
                // Body data on the inputs belongs to entry idx-1.
                if ((idx_q != 7'd0) && (i_Body_x == cand_x_q) && (i_Body_y == cand_y_q)) begin
                    w_hit = 1'b1;
                end else if (idx_q == size_q) begin
                    item_x_d = cand_x_q;
                    item_y_d = cand_y_q;
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q + 7'd1;
                end
            end
            DONE:    state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (w_hit) begin
            if (try_q == TRY_LAST) begin
                state_d = FAIL;
            end else begin
                try_d   = try_q + TW'(1);
                state_d = DRAW;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED;
            size_q   <= '0;
            head_x_q <= '0;
            head_y_q <= '0;
            cand_x_q <= '0;
            cand_y_q <= '0;
            item_x_q <= 6'(ITEM_X0);
            item_y_q <= 6'(ITEM_Y0);
            idx_q    <= '0;
            addr_q   <= '0;
            try_q    <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            size_q   <= size_d;
            head_x_q <= head_x_d;
            head_y_q <= head_y_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
            item_x_q <= item_x_d;
            item_y_q <= item_y_d;
            idx_q    <= idx_d;
            try_q    <= try_d;
            if (w_rd) begin
                addr_q <= idx_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_snake_item_placer.sv
`default_nettype none
// Testbench for snake_item_placer: directed and random requests predicted by a
// transaction-level placement model; a monitor pops expectations on Done/Fail.
module tb_snake_item_placer;

    localparam int          XSIZE    = 48;
    localparam int          YSIZE    = 64;
    localparam int          MAX_SIZE = 100;
    localparam int          MAX_TRY  = 16;
    localparam logic [15:0] SEED     = 16'hACE1;
    localparam int          ITEM_X0  = 12;
    localparam int          ITEM_Y0  = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [11:0] size_in = '0;
    logic [5:0]  hx = '0, hy = '0;
    logic        body_rd;
    logic [6:0]  body_addr;
    logic [5:0]  bx = '0, by = '0;
    logic [5:0]  ix, iy;
    logic        busy, done, fail;

    always #5 clk = ~clk;

    snake_item_placer #(
        .XSIZE(XSIZE), .YSIZE(YSIZE), .MAX_SIZE(MAX_SIZE), .MAX_TRY(MAX_TRY),
        .SEED(SEED), .ITEM_X0(ITEM_X0), .ITEM_Y0(ITEM_Y0)
    ) dut (
        .i_Clk(clk), .i_Rst(rst_n), .i_Req(req), .i_Size(size_in),
        .i_Head_x(hx), .i_Head_y(hy),
        .o_Body_Rd(body_rd), .o_Body_Addr(body_addr),
        .i_Body_x(bx), .i_Body_y(by),
        .o_Item_x(ix), .o_Item_y(iy),
        .o_Busy(busy), .o_Done(done), .o_Fail(fail)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference LFSR sequence: 16-bit Fibonacci, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    logic [15:0] lfsr_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= SEED;
        else        lfsr_m <= lfsr_next(lfsr_m);
    end

    // Body storage model and echo mode (always returns the candidate under scan).
    logic [5:0]  mem_x [MAX_SIZE];
    logic [5:0]  mem_y [MAX_SIZE];
    bit          echo = 1'b0;
    logic [11:0] echo_q [$];

    typedef struct {
        bit         is_fail;
        logic [5:0] x;
        logic [5:0] y;
        int         cyc;
        int         reads;
        int         addr;
    } exp_t;
    exp_t sb [$];

    logic [5:0] item_x_m = 6'(ITEM_X0);
    logic [5:0] item_y_m = 6'(ITEM_Y0);
    int         addr_m   = 0;

    // Whole-search outcome from the placement rules; ncyc counts cycles from
    // the first draw cycle to the Done/Fail cycle.
    function automatic void run_model(input logic [15:0] start, input int sz,
                                      input logic [5:0] hdx, input logic [5:0] hdy,
                                      input bit do_push, output exp_t e, output int ncyc,
                                      output bit have_first, output logic [11:0] first_c);
        logic [15:0] l;
        logic [5:0]  cx, cy;
        int          tries, j, span;
        bit          fin, hit;
        l = start; tries = 0; fin = 0;
        e.is_fail = 0; e.x = item_x_m; e.y = item_y_m; e.reads = 0; e.addr = addr_m; e.cyc = 0;
        ncyc = 0; have_first = 0; first_c = '0;
        while (!fin) begin
            cx = l[5:0]; cy = l[13:8];
            l = lfsr_next(l);
            ncyc++;
            hit = 0;
            if (cx < 1 || cx > XSIZE - 2 || cy < 1 || cy > YSIZE - 2) continue;
            if (cx == hdx && cy == hdy) begin
                hit = 1;
            end else if (sz == 0) begin
                fin = 1; e.x = cx; e.y = cy;
            end else begin
                if (!have_first) begin have_first = 1; first_c = {cx, cy}; end
                j = -1;
                if (echo) begin
                    j = 0;
                    if (do_push) echo_q.push_back({cx, cy});
                end else begin
                    for (int k = 0; k < sz; k++) begin
                        if (mem_x[k] == cx && mem_y[k] == cy) begin j = k; break; end
                    end
                end
                if (j < 0) begin
                    span = sz + 1; e.reads += sz; e.addr = sz - 1;
                    fin = 1; e.x = cx; e.y = cy;
                end else begin
                    span = j + 2;
                    e.reads += (j + 2 < sz) ? j + 2 : sz;
                    e.addr = (j + 1 < sz) ? j + 1 : sz - 1;
                    hit = 1;
                end
                for (int k = 0; k < span; k++) l = lfsr_next(l);
                ncyc += span;
            end
            if (hit) begin
                if (tries == MAX_TRY - 1) begin fin = 1; e.is_fail = 1; end
                else tries++;
            end
        end
    endfunction

    // Responder: one-cycle read latency.
    logic        s_rd = 1'b0;
    logic [6:0]  s_addr = '0;
    logic [11:0] echo_cur = '0;
    always @(negedge clk) begin s_rd = body_rd; s_addr = body_addr; end
    always @(posedge clk) begin
        #1;
        if (s_rd) begin
            if (echo) begin
                if (s_addr == 7'd0) echo_cur = (echo_q.size() > 0) ? echo_q.pop_front() : 12'd0;
                {bx, by} = echo_cur;
            end else if (int'(s_addr) < MAX_SIZE) begin
                bx = mem_x[s_addr]; by = mem_y[s_addr];
            end
        end
    end

    // Monitor / scoreboard.
    int         reads_seen = 0;
    bit         prev_rd = 1'b0;
    logic [6:0] prev_addr = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (body_rd) begin
                reads_seen++;
                check("addr_seq", body_addr, prev_rd ? 7'(prev_addr + 7'd1) : 7'd0);
            end
            prev_rd = body_rd; prev_addr = body_addr;
            if (done || fail) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("fail_pulse", fail, e.is_fail);
                    check("done_pulse", done, !e.is_fail);
                    check("item_x", ix, e.x);
                    check("item_y", iy, e.y);
                    check("pulse_cycle", cyc, e.cyc);
                    check("read_count", reads_seen, e.reads);
                    check("final_addr", body_addr, e.addr);
                    check("busy_at_pulse", busy, 1);
                end
                reads_seen = 0;
            end
        end
    end

    task automatic fill_mem(input bit random_cells);
        for (int k = 0; k < MAX_SIZE; k++) begin
            if (random_cells) begin
                mem_x[k] = 6'($urandom_range(1, XSIZE - 2));
                mem_y[k] = 6'($urandom_range(1, YSIZE - 2));
            end else begin
                mem_x[k] = '0; mem_y[k] = '0;
            end
        end
    endtask

    // Called #1 after a posedge with the DUT idle in that cycle; returns in the
    // idle cycle after the pulse. mode 0: single pulse, 1: random req/inputs
    // while busy, 2: req and random inputs while busy, req kept high after.
    task automatic issue(input int sz_raw, input logic [5:0] hdx, input logic [5:0] hdy,
                         input int mode);
        exp_t        e;
        int          ncyc, sz;
        bit          hf;
        logic [11:0] fc;
        sz = (sz_raw > MAX_SIZE) ? MAX_SIZE : sz_raw;
        run_model(lfsr_next(lfsr_m), sz, hdx, hdy, 1'b1, e, ncyc, hf, fc);
        e.cyc = cyc + 1 + ncyc;
        sb.push_back(e);
        item_x_m = e.x; item_y_m = e.y; addr_m = e.addr;
        req = 1'b1; size_in = 12'(sz_raw); hx = hdx; hy = hdy;
        @(posedge clk); #1;
        check("busy_first_draw", busy, 1);
        repeat (ncyc) begin
            if (mode == 0) begin
                req = 1'b0;
            end else begin
                req     = (mode == 2) ? 1'b1 : 1'($urandom);
                size_in = 12'($urandom);
                hx      = 6'($urandom);
                hy      = 6'($urandom);
            end
            @(posedge clk); #1;
        end
        req = (mode == 2);
        @(posedge clk); #1;
    endtask

    task automatic plant_first(input int sz, input logic [5:0] hdx, input logic [5:0] hdy,
                               input int idx);
        exp_t        e;
        int          n;
        bit          hf;
        logic [11:0] fc;
        run_model(lfsr_next(lfsr_m), sz, hdx, hdy, 1'b0, e, n, hf, fc);
        if (hf) begin mem_x[idx] = fc[11:6]; mem_y[idx] = fc[5:0]; end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sz_raw, mode;
        fill_mem(1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_rd", body_rd, 0);
        check("rst_addr", body_addr, 0);
        check("rst_item_x", ix, ITEM_X0);
        check("rst_item_y", iy, ITEM_Y0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a 50-entry scan.
        req = 1'b1; size_in = 12'd50; hx = 6'd0; hy = 6'd0;
        @(posedge clk); #1;
        req = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (body_rd && body_addr == 7'd20) break;
            @(posedge clk); #1;
        end
        check("reach_idx20", body_rd && body_addr == 7'd20, 1);
        rst_n = 1'b0;
        #1;
        sb.delete(); echo_q.delete();
        reads_seen = 0; prev_rd = 1'b0; prev_addr = '0;
        item_x_m = 6'(ITEM_X0); item_y_m = 6'(ITEM_Y0); addr_m = 0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_fail", fail, 0);
        check("midrst_rd", body_rd, 0);
        check("midrst_item_x", ix, ITEM_X0);
        check("midrst_item_y", iy, ITEM_Y0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty body: first in-range non-head draw wins.
        issue(0, 6'd24, 6'd32, 0);
        check("size0_in_range", (ix >= 1 && ix <= XSIZE - 2 && iy >= 1 && iy <= YSIZE - 2), 1);

        // Five-entry body that never matches.
        issue(5, 6'd0, 6'd0, 0);

        // Entry 2 matches the first candidate: abort and redraw.
        plant_first(5, 6'd0, 6'd0, 2);
        issue(5, 6'd0, 6'd0, 0);
        fill_mem(1'b0);

        // Every scan collides: give up after MAX_TRY tries.
        echo = 1'b1;
        issue(3, 6'd0, 6'd0, 0);
        echo = 1'b0;
        echo_q.delete();

        // Oversize body clamps to MAX_SIZE; inputs wiggled while busy.
        issue(200, 6'd0, 6'd0, 1);

        // Random traffic with back-to-back requests and planted collisions.
        for (int t = 0; t < 25; t++) begin
            sz_raw = $urandom_range(0, 130);
            mode   = (t == 24) ? $urandom_range(0, 1) : $urandom_range(0, 2);
            fill_mem(1'b1);
            if (sz_raw > 0 && $urandom_range(0, 1) == 1)
                plant_first((sz_raw > MAX_SIZE) ? MAX_SIZE : sz_raw, 6'd0, 6'd0,
                            $urandom_range(0, ((sz_raw > MAX_SIZE) ? MAX_SIZE : sz_raw) - 1));
            if ($urandom_range(0, 3) == 0)
                issue(sz_raw, 6'($urandom_range(1, XSIZE - 2)), 6'($urandom_range(1, YSIZE - 2)), mode);
            else
                issue(sz_raw, 6'd0, 6'd0, mode);
        end
        req = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
